// File: rtl/radix2_divider_nbit.sv
// Iterative radix-2 restoring divider with per-operand signedness and valid/ready handshakes.
// Optional DIV_SPECIAL_FASTPATH_EN: divide-by-zero and signed overflow go straight to DONE.
module radix2_divider_nbit #(
  parameter  int DIV_SIZE = 32,
  localparam int CNT_W    = $clog2(DIV_SIZE + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIV_SIZE-1:0] in_op1,
  input  logic [DIV_SIZE-1:0] in_op2,
  input  logic                in_op1_signed,
  input  logic                in_op2_signed,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DIV_SIZE-1:0] out_quot,
  output logic [DIV_SIZE-1:0] out_rem,
  output logic                out_div_by_zero,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DIV_SIZE-1:0] ZERO    = {DIV_SIZE{1'b0}};
  localparam logic [DIV_SIZE-1:0] ONES    = {DIV_SIZE{1'b1}};
  localparam logic [DIV_SIZE-1:0] ONE     = {{(DIV_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DIV_SIZE - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [DIV_SIZE-1:0] quot_r;
  logic [DIV_SIZE-1:0] prem_r;
  logic [DIV_SIZE-1:0] dvsr_r;
  logic [DIV_SIZE-1:0] op1_raw_r;
  logic                quot_neg_r;
  logic                rem_neg_r;
  logic                dbz_r;
  logic [DIV_SIZE-1:0] out_quot_r;
  logic [DIV_SIZE-1:0] out_rem_r;
  logic                out_dbz_r;
  logic                in_ready_s;
  logic                out_valid_s;

  logic                accept_s;
  logic                op1_neg_s;
  logic                op2_neg_s;
  logic [DIV_SIZE-1:0] op1_mag_s;
  logic [DIV_SIZE-1:0] op2_mag_s;
  logic                op2_zero_s;
  logic [DIV_SIZE:0]   shifted_s;
  logic [DIV_SIZE:0]   trial_s;
`ifdef DIV_SPECIAL_FASTPATH_EN
  logic                ovf_s;
  logic                special_s;
`endif

  // Operand magnitudes and one restoring-division trial step.
  always_comb begin
    accept_s   = in_valid && (state_r == IDLE);
    op1_neg_s  = in_op1_signed && in_op1[DIV_SIZE-1];
    op2_neg_s  = in_op2_signed && in_op2[DIV_SIZE-1];
    op1_mag_s  = op1_neg_s ? (~in_op1 + ONE) : in_op1;
    op2_mag_s  = op2_neg_s ? (~in_op2 + ONE) : in_op2;
    op2_zero_s = (in_op2 == ZERO);
    shifted_s  = {prem_r, quot_r[DIV_SIZE-1]};
    trial_s    = shifted_s - {1'b0, dvsr_r};
  end

`ifdef DIV_SPECIAL_FASTPATH_EN
  // Special operand pairs whose result is known without iterating.
  always_comb begin
    ovf_s     = in_op1_signed && in_op2_signed &&
                (in_op1 == {1'b1, {(DIV_SIZE-1){1'b0}}}) && (in_op2 == ONES);
    special_s = op2_zero_s || ovf_s;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef DIV_SPECIAL_FASTPATH_EN
          state_nxt_s = special_s ? DONE : CALC;
`else
          state_nxt_s = CALC;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_MAX) begin
          state_nxt_s = FIXUP;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIXUP: state_nxt_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s  = 1'b1;
      DONE:    out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      quot_r     <= ZERO;
      prem_r     <= ZERO;
      dvsr_r     <= ZERO;
      op1_raw_r  <= ZERO;
      quot_neg_r <= 1'b0;
      rem_neg_r  <= 1'b0;
      dbz_r      <= 1'b0;
      out_quot_r <= ZERO;
      out_rem_r  <= ZERO;
      out_dbz_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            quot_r     <= op1_mag_s;
            prem_r     <= ZERO;
            dvsr_r     <= op2_mag_s;
            op1_raw_r  <= in_op1;
            quot_neg_r <= op1_neg_s ^ op2_neg_s;
            rem_neg_r  <= op1_neg_s;
            dbz_r      <= op2_zero_s;
`ifdef DIV_SPECIAL_FASTPATH_EN
            if (special_s) begin
              out_quot_r <= op2_zero_s ? ONES : in_op1;
              out_rem_r  <= op2_zero_s ? in_op1 : ZERO;
              out_dbz_r  <= op2_zero_s;
            end
`endif
          end
        end
        CALC: begin
          // A negative trial keeps the shifted remainder (restore) and emits a 0 bit.
          prem_r <= trial_s[DIV_SIZE] ? shifted_s[DIV_SIZE-1:0] : trial_s[DIV_SIZE-1:0];
          quot_r <= {quot_r[DIV_SIZE-2:0], ~trial_s[DIV_SIZE]};
          cnt_r  <= cnt_r + CNT_ONE;
        end
        FIXUP: begin
          if (dbz_r) begin
            out_quot_r <= ONES;
            out_rem_r  <= op1_raw_r;
          end else begin
            out_quot_r <= quot_neg_r ? (~quot_r + ONE) : quot_r;
            out_rem_r  <= rem_neg_r ? (~prem_r + ONE) : prem_r;
          end
          out_dbz_r <= dbz_r;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_s;
  assign out_valid       = out_valid_s;
  assign out_quot        = out_quot_r;
  assign out_rem         = out_rem_r;
  assign out_div_by_zero = out_dbz_r;

endmodule
